// File: rtl/adder8bit_seq_ctrl.sv
// Multi-precision add sequencer: one shared 8-bit adder walks NBYTES-wide operands
// LSB byte first through a registered carry, behind valid/ready handshakes.

module adder8bit (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] s_o,
    output logic       co_o
);
    assign {co_o, s_o} = 9'(a_i) + 9'(b_i) + 9'(ci_i);
endmodule

module adder8bit_seq_ctrl #(
    parameter int unsigned NBYTES = 4,
    parameter int unsigned CNTW   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);
    localparam int unsigned W    = 8 * NBYTES;
    localparam int unsigned SHW  = CNTW + 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [SHW-1:0]  byte_sh;
    logic [W-1:0]    a_shift, b_shift;
    logic [7:0]      add_s;
    logic            add_co;

    // Byte lane selected by the index; shifts keep the select width-safe for any NBYTES.
    assign byte_sh = {idx_q, 3'b000};
    assign a_shift = a_q >> byte_sh;
    assign b_shift = b_q >> byte_sh;

    adder8bit u_add (
        .a_i  (a_shift[7:0]),
        .b_i  (b_shift[7:0]),
        .ci_i (carry_q),
        .s_o  (add_s),
        .co_o (add_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = cin;
                    idx_d   = '0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                sum_d   = (sum_q & ~(W'(8'hFF) << byte_sh)) | (W'(add_s) << byte_sh);
                carry_d = add_co;
                if (idx_q == CNTW'(NBYTES - 1)) begin
                    cout_d  = add_co;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + CNTW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_ADD);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_adder8bit_seq_ctrl.sv
// Randomized and directed bench for adder8bit_seq_ctrl against an arithmetic reference model.

module tb_adder8bit_seq_ctrl;
    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, busy;
    logic [W-1:0] op_a, op_b, sum;

    logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1, busy1;
    logic [7:0]   op_a1, op_b1, sum1;

    int n_vec = 0;
    int n_err = 0;

    logic         pend_en;
    logic [W-1:0] pend_a, pend_b;

    always #5 clk = ~clk;

    adder8bit_seq_ctrl #(.NBYTES(NB), .CNTW(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
    );

    adder8bit_seq_ctrl #(.NBYTES(1), .CNTW(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .op_a(op_a1), .op_b(op_b1), .cin(cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .sum(sum1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-word arithmetic, signed overflow from operand/result sign bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         output logic [W-1:0] s, output logic co, output logic ov);
        logic [W:0] full;
        full = (W+1)'(a) + (W+1)'(b) + (W+1)'(ci);
        s    = full[W-1:0];
        co   = full[W];
        ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, NBYTES adds, optional backpressure, handshake.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input int hold);
        logic [W-1:0] es;
        logic         ec, eo;
        int           cyc, bcnt;
        model(a, b, ci, es, ec, eo);
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = ci;
        cyc  = 0;
        while (!in_ready && cyc < 20) begin
            tick();
            cyc++;
        end
        check("ready_before_accept", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        cin  = 1'($urandom);
        check("in_ready_after_accept", 64'(in_ready), 64'd0);
        cyc  = 0;
        bcnt = 0;
        while (!out_valid && cyc < 100) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
        check("latency", 64'(cyc), 64'(NB));
        check("busy_cycles", 64'(bcnt), 64'(NB));
        check("sum", 64'(sum), 64'(es));
        check("cout", 64'(cout), 64'(ec));
        check("ovf", 64'(ovf), 64'(eo));
        for (int i = 0; i < hold; i++) begin
            if (pend_en) begin
                in_valid = 1'b1;
                op_a = pend_a;
                op_b = pend_b;
            end
            tick();
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_sum", 64'(sum), 64'(es));
            check("bp_cout_ovf", 64'({cout, ovf}), 64'({ec, eo}));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("post_hs_out_valid", 64'(out_valid), 64'd0);
        check("post_hs_in_ready", 64'(in_ready), 64'(!(pend_en == 1'b0 && in_valid == 1'b1)));
        check("idle_sum_kept", 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           cyc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0;
        op_a = '0; op_b = '0; pend_en = 1'b0; pend_a = '0; pend_b = '0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; cin1 = 1'b0; op_a1 = '0; op_b1 = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);

        do_op(32'h000000FF, 32'h00000001, 1'b0, 0);
        do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1);
        do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
        do_op(32'h80000000, 32'h80000000, 1'b0, 0);

        // Backpressure with a new request pending, which is taken right after the handshake.
        pend_en = 1'b1;
        pend_a  = 32'h12345678;
        pend_b  = 32'h11111111;
        do_op(32'h00010203, 32'hFFFF0000, 1'b0, 3);
        pend_en = 1'b0;
        do_op(32'h12345678, 32'h11111111, 1'b0, 0);

        // Reset two bytes into an add: operation discarded, no carry carried over.
        in_valid = 1'b1; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        do_op(32'h00000010, 32'h00000020, 1'b0, 0);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom;
            rb = $urandom;
            if (k % 8 == 0) ra = 32'hFFFFFFFF;
            if (k % 8 == 1) rb = ~ra;
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Single-byte build: 0x80 + 0x80.
        in_valid1 = 1'b1; op_a1 = 8'h80; op_b1 = 8'h80; cin1 = 1'b0;
        check("nb1_ready", 64'(in_ready1), 64'd1);
        tick();
        in_valid1 = 1'b0;
        cyc = 0;
        while (!out_valid1 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("nb1_latency", 64'(cyc), 64'd1);
        check("nb1_sum", 64'(sum1), 64'h00);
        check("nb1_cout", 64'(cout1), 64'd1);
        check("nb1_ovf", 64'(ovf1), 64'd1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("nb1_post_hs", 64'({in_ready1, out_valid1}), 64'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
